// File: rtl/cmos_capture_pack.sv
// Packs 8-bit CMOS sensor bytes into RGB565 frame-FIFO writes, with frame settling and geometry
// checks. Define CAPTURE_TEST_PATTERN_EN to replace pixel data with 8 vertical colour bars.
module cmos_capture_pack #(
    parameter int unsigned WAIT_FRAMES = 10,
    parameter int unsigned H_PIXELS    = 640,
    parameter int unsigned V_LINES     = 480,
    parameter int unsigned LOAD_CYCLES = 4
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic        frm_wr_en,
    output logic [15:0] frm_wr_data,
    output logic        frm_load,
    output logic        frame_done,
    output logic        frame_err,
    output logic [9:0]  pix_cnt,
    output logic [9:0]  line_cnt
);
    typedef enum logic [1:0] {StIdle, StSettle, StWaitSof, StActive} state_t;

    state_t      r_state, w_state_d;
    logic        r_vs1, r_vs2, r_hs1, r_hs2;
    logic [7:0]  r_d1, r_hi;
    logic        r_phase;
    logic [15:0] r_settle_cnt;
    logic [7:0]  r_load_cnt;
    logic        r_wr_en, r_frame_done, r_frame_err, r_err_clr;
    logic [15:0] r_wr_data;
    logic [9:0]  r_pix_cnt, r_line_cnt;
    logic        w_vs_rise, w_hs_fall, w_sof, w_load_free, w_settle_last;
    logic [15:0] w_pix_data;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs1 <= 1'b0;
            r_vs2 <= 1'b0;
            r_hs1 <= 1'b0;
            r_hs2 <= 1'b0;
            r_d1  <= '0;
        end else begin
            r_vs1 <= cam_vsync;
            r_vs2 <= r_vs1;
            r_hs1 <= cam_href;
            r_hs2 <= r_hs1;
            r_d1  <= cam_data;
        end
    end

    assign w_vs_rise     = r_vs1 & ~r_vs2;
    assign w_hs_fall     = ~r_hs1 & r_hs2;
    assign w_sof         = w_vs_rise && (r_state == StWaitSof || r_state == StActive);
    assign w_settle_last = (WAIT_FRAMES == 0) ||
                           (w_vs_rise && (32'(r_settle_cnt) + 32'd1 >= WAIT_FRAMES));
    // The load window closes on this edge when the counter is at 1, so a write may follow it.
    assign w_load_free   = (r_load_cnt <= 8'd1);

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state != StSettle) begin
                r_settle_cnt <= '0;
            end else if (w_vs_rise) begin
                r_settle_cnt <= r_settle_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    w_state_d = StSettle;
            StSettle:  if (w_settle_last) w_state_d = StWaitSof;
            StWaitSof: if (w_vs_rise) w_state_d = StActive;
            StActive:  w_state_d = StActive;
            default:   w_state_d = StIdle;
        endcase
        if (!capture_en) begin
            w_state_d = StIdle;
        end
    end

`ifdef CAPTURE_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_PIXELS >= 8) ? H_PIXELS / 8 : 1;
    logic [31:0] w_bar;
    assign w_bar = 32'(r_pix_cnt) / BAR_W;

    always_comb begin
        case (w_bar)
            32'd0:   w_pix_data = 16'hFFFF;
            32'd1:   w_pix_data = 16'hFFE0;
            32'd2:   w_pix_data = 16'h07FF;
            32'd3:   w_pix_data = 16'h07E0;
            32'd4:   w_pix_data = 16'hF81F;
            32'd5:   w_pix_data = 16'hF800;
            32'd6:   w_pix_data = 16'h001F;
            default: w_pix_data = 16'h0000;
        endcase
    end
`else
    assign w_pix_data = {r_hi, r_d1};
`endif

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi         <= '0;
            r_phase      <= 1'b0;
            r_load_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_clr    <= 1'b0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
        end else if (!capture_en || r_state == StIdle) begin
            r_hi         <= '0;
            r_phase      <= 1'b0;
            r_load_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_clr    <= 1'b0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_clr    <= 1'b0;
            if (r_load_cnt != 8'd0) begin
                r_load_cnt <= r_load_cnt - 8'd1;
            end
            if (r_err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_sof) begin
                r_load_cnt <= 8'(LOAD_CYCLES);
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_phase    <= 1'b0;
                // A short frame shows frame_err for one cycle before the new frame clears it.
                if (r_state == StActive) begin
                    r_err_clr <= 1'b1;
                    if (32'(r_line_cnt) == V_LINES) begin
                        r_frame_done <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_frame_err <= 1'b0;
                end
            end else if (r_state == StActive) begin
                if (w_hs_fall) begin
                    if (32'(r_pix_cnt) != H_PIXELS || r_phase) begin
                        r_frame_err <= 1'b1;
                    end
                    r_pix_cnt <= '0;
                    if (r_line_cnt != 10'd1023) begin
                        r_line_cnt <= r_line_cnt + 10'd1;
                    end
                end
                if (!r_hs1) begin
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_hi    <= r_d1;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (w_load_free) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_pix_data;
                        if (r_pix_cnt != 10'd1023) begin
                            r_pix_cnt <= r_pix_cnt + 10'd1;
                        end
                    end
                end
            end
        end
    end

    assign frm_wr_en   = r_wr_en;
    assign frm_wr_data = r_wr_data;
    assign frm_load    = (r_load_cnt != 8'd0);
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign pix_cnt     = r_pix_cnt;
    assign line_cnt    = r_line_cnt;
endmodule

// File: tb/tb_cmos_capture_pack.sv
// Bench for cmos_capture_pack: a frame-level model predicts each pixel write (data and cycle),
// frame_done/frame_err per frame and frm_load windows; a small geometry keeps runs short.
module tb_cmos_capture_pack;
    localparam int WF = 2;
    localparam int HP = 16;
    localparam int VL = 4;
    localparam int LC = 4;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n, vs, hs, en;
    logic [7:0]  d;
    logic        frm_wr_en, frm_load, frame_done, frame_err;
    logic [15:0] frm_wr_data;
    logic [9:0]  pix_cnt, line_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    vec_t tab[16];
    bit   mon_ignore = 1'b0;
    int   load_len = 0;
    int   load_pulses = 0;
    int   exp_loads = 0;
    int   m_vs = 0;
    int   m_lines = 0;
    bit   m_active = 1'b0;
    bit   m_err = 1'b0;

    cmos_capture_pack #(
        .WAIT_FRAMES(WF),
        .H_PIXELS   (HP),
        .V_LINES    (VL),
        .LOAD_CYCLES(LC)
    ) dut (
        .cam_pclk   (clk),
        .rst_n      (rst_n),
        .cam_vsync  (vs),
        .cam_href   (hs),
        .cam_data   (d),
        .capture_en (en),
        .frm_wr_en  (frm_wr_en),
        .frm_wr_data(frm_wr_data),
        .frm_load   (frm_load),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .pix_cnt    (pix_cnt),
        .line_cnt   (line_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int idx, input logic [15:0] raw);
`ifdef CAPTURE_TEST_PATTERN_EN
        int bar;
        bar = idx / (HP / 8);
        case (bar)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        return raw;
`endif
    endfunction

    always @(negedge clk) begin : mon
        wr_t e;
        if (frm_wr_en && !mon_ignore) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", int'(frm_wr_data), int'(e.data));
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (frm_load) begin
            if (load_len == 0) begin
                load_pulses++;
                check("load_pix_cnt", int'(pix_cnt), 0);
                check("load_line_cnt", int'(line_cnt), 0);
            end
            load_len++;
        end else if (load_len != 0) begin
            check("load_len", load_len, LC);
            load_len = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_wr_en"}, int'(frm_wr_en), 0);
        check({tag, "_wr_data"}, int'(frm_wr_data), 0);
        check({tag, "_load"}, int'(frm_load), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        check({tag, "_pix"}, int'(pix_cnt), 0);
        check({tag, "_line"}, int'(line_cnt), 0);
    endtask

    task automatic model_reset();
        m_vs = 0;
        m_active = 1'b0;
        m_lines = 0;
        m_err = 1'b0;
    endtask

    task automatic vsync();
        bit done_seen = 1'b0;
        bit err_seen = 1'b0;
        bit was_active = m_active;
        int lines = m_lines;
        bit err = m_err;
        vs = 1'b1;
        m_vs++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) vs = 1'b0;
            done_seen |= frame_done;
            err_seen  |= frame_err;
        end
        if (was_active) begin
            check("frame_done", int'(done_seen), int'(lines == VL));
            check("sof_frame_err", int'(err_seen), int'(err || lines != VL));
        end else begin
            check("no_done_outside_active", int'(done_seen), 0);
        end
        if (m_vs > WF) begin
            m_active = 1'b1;
            exp_loads++;
            check("sof_pix_cnt", int'(pix_cnt), 0);
            check("sof_line_cnt", int'(line_cnt), 0);
            check("sof_err_cleared", int'(frame_err), 0);
        end
        m_lines = 0;
        m_err = 1'b0;
    endtask

    task automatic send_line(input int nbytes, input bit use_tab);
        int         pairs = 0;
        bit         odd = 1'b0;
        logic [7:0] hi = '0;
        logic [7:0] b;
        vec_t       v;
        wr_t        e;
        for (int i = 0; i < nbytes; i++) begin
            v = tab[(i / 2) % 16];
            b = use_tab ? ((i % 2 == 0) ? v.hi : v.lo) : 8'($urandom);
            hs = 1'b1;
            d  = b;
            if (m_active) begin
                if (!odd) begin
                    hi  = b;
                    odd = 1'b1;
                end else begin
                    e.data = exp_pix(pairs, use_tab ? v.exp : {hi, b});
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                    pairs++;
                    odd = 1'b0;
                end
            end
            tick();
        end
        hs = 1'b0;
        d  = '0;
        if (m_active) begin
            if (pairs != HP || odd) m_err = 1'b1;
            m_lines++;
        end
        repeat (5) tick();
        if (m_active) begin
            check("line_frame_err", int'(frame_err), int'(m_err));
            check("line_cnt", int'(line_cnt), m_lines);
            check("pix_cnt_cleared", int'(pix_cnt), 0);
        end
    endtask

    task automatic good_frame(input bit first_tab);
        vsync();
        for (int l = 0; l < VL; l++) send_line(2 * HP, first_tab && l == 0);
    endtask

    initial begin
        int nl, nb;
        tab = '{'{8'hA5, 8'h3C, 16'hA53C}, '{8'h00, 8'h00, 16'h0000}, '{8'hFF, 8'hFF, 16'hFFFF},
                '{8'h12, 8'h34, 16'h1234}, '{8'h80, 8'h01, 16'h8001}, '{8'h7F, 8'hFE, 16'h7FFE},
                '{8'h55, 8'hAA, 16'h55AA}, '{8'hAA, 8'h55, 16'hAA55}, '{8'h0F, 8'h0F, 16'h0F0F},
                '{8'hF0, 8'hF0, 16'hF0F0}, '{8'hC3, 8'hC3, 16'hC3C3}, '{8'h01, 8'h02, 16'h0102},
                '{8'hFE, 8'hDC, 16'hFEDC}, '{8'hBA, 8'h98, 16'hBA98}, '{8'h76, 8'h54, 16'h7654},
                '{8'h32, 8'h10, 16'h3210}};
        rst_n = 1'b0;
        en = 1'b0;
        vs = 1'b0;
        hs = 1'b0;
        d = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk_zero("idle_disabled");

        en = 1'b1;
        model_reset();
        repeat (4) tick();
        send_line(2 * HP, 1'b0);
        for (int f = 0; f < WF; f++) good_frame(1'b0);
        good_frame(1'b1);
        // short line ending in an odd byte, then good lines
        vsync();
        send_line(2 * HP - 1, 1'b0);
        for (int l = 1; l < VL; l++) send_line(2 * HP, 1'b0);
        for (int f = 0; f < 6; f++) begin
            vsync();
            nl = ($urandom_range(0, 3) == 0) ? VL - 1 + 2 * $urandom_range(0, 1) : VL;
            for (int l = 0; l < nl; l++) begin
                nb = ($urandom_range(0, 4) == 0) ? 2 * HP - 2 + $urandom_range(0, 4) : 2 * HP;
                send_line(nb, 1'b0);
            end
        end
        vsync();
        check("writes_drained", exp_q.size(), 0);

        // capture_en dropped mid-line
        mon_ignore = 1'b1;
        hs = 1'b1;
        repeat (7) begin
            d = 8'($urandom);
            tick();
        end
        en = 1'b0;
        tick();
        chk_zero("en_drop");
        hs = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        mon_ignore = 1'b0;
        model_reset();

        // reset asserted mid-frame after re-reaching ACTIVE
        en = 1'b1;
        repeat (4) tick();
        for (int f = 0; f <= WF; f++) begin
            vsync();
            send_line(2 * HP, 1'b0);
        end
        mon_ignore = 1'b1;
        hs = 1'b1;
        repeat (5) begin
            d = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid_frame");
        tick();
        hs = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        mon_ignore = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int f = 0; f < WF; f++) good_frame(1'b0);
        good_frame(1'b1);
        vsync();
        check("writes_drained_end", exp_q.size(), 0);
        check("load_pulse_count", load_pulses, exp_loads);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
